axi_rd_arbiter: RTL

- Parametrised N-client AXI4 read arbiter. Successor to the single-client AXI read wrapper.
- Sits between the fetch unit, the data path and the D-cache refill engine, and drives the one AXI read-address/read-data channel pair to memory.
- Adds round-robin arbitration, INCR bursts of variable length, a beat counter with last-beat checking, and per-beat error reporting.
- One transaction is outstanding at a time.

---
 rtl/axi_pkg.sv | 18 +
 rtl/axi_rd_arbiter_if.sv | 51 +++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/axi_rd_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-arbiter definitions: burst/response encodings and the arbiter FSM state type.
package axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Width of a client index; a single-client build still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Client request/response bundle plus the AXI AR/R channel pair seen by the read arbiter.
interface axi_rd_arbiter_if #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ID_W      = 4
);

    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*8-1:0]      req_len;
    logic [NUM_PORTS*3-1:0]      req_size;
    logic [NUM_PORTS-1:0]        resp_valid;
    logic [NUM_PORTS-1:0]        resp_ready;
    logic [DATA_W-1:0]           resp_data;
    logic                        resp_last;
    logic                        resp_err;
    logic                        proto_err;

    logic [ID_W-1:0]             m_arid;
    logic [ADDR_W-1:0]           m_araddr;
    logic [7:0]                  m_arlen;
    logic [2:0]                  m_arsize;
    logic [1:0]                  m_arburst;
    logic                        m_arvalid;
    logic                        m_arready;
    logic [ID_W-1:0]             m_rid;
    logic [DATA_W-1:0]           m_rdata;
    logic [1:0]                  m_rresp;
    logic                        m_rlast;
    logic                        m_rvalid;
    logic                        m_rready;

    // Arbiter side.
    modport master (
        input  req_valid, req_addr, req_len, req_size, resp_ready,
        input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output req_ready, resp_valid, resp_data, resp_last, resp_err, proto_err,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
    );

    // Clients and memory side.
    modport slave (
        output req_valid, req_addr, req_len, req_size, resp_ready,
        output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  req_ready, resp_valid, resp_data, resp_last, resp_err, proto_err,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = IDX_W'((32'(ptr) + i) % NUM_PORTS);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-client AXI4 read arbiter: round-robin grant, one INCR burst outstanding, beats passed
// straight through to the granted client with last-beat and ID checking.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ID_W      = 4
) (
    input logic clk,
    input logic rst,
    axi_rd_arbiter_if.master bus
);

    localparam int unsigned IDX_W = idx_width(NUM_PORTS);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic              proto_err_q, proto_err_d;

    logic [NUM_PORTS-1:0] arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [7:0]           sel_len;
    logic [2:0]           sel_size;
    logic                 in_addr, in_data, rready, r_hs;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Mux the winning client's request fields out of the flattened buses.
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_size = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (arb_idx == IDX_W'(p)) begin
                sel_addr = bus.req_addr[p*ADDR_W +: ADDR_W];
                sel_len  = bus.req_len[p*8 +: 8];
                sel_size = bus.req_size[p*3 +: 3];
            end
        end
    end

    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);
    assign rready  = in_data & bus.resp_ready[grant_q];
    assign r_hs    = rready & bus.m_rvalid;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        proto_err_d = proto_err_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_d    = ADDR;
                    grant_d    = arb_idx;
                    beat_cnt_d = '0;
                    addr_d     = sel_addr;
                    len_d      = sel_len;
                    size_d     = sel_size;
                end
            end
            ADDR: begin
                if (bus.m_arready) state_d = DATA;
            end
            DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // rlast must coincide exactly with the len-th beat; the burst still ends
                    // on rlast so a bad slave cannot wedge the arbiter.
                    if ((bus.m_rlast != (beat_cnt_q == len_q)) ||
                        (bus.m_rid != ID_W'(grant_q))) begin
                        proto_err_d = 1'b1;
                    end
                    if (bus.m_rlast) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        bus.req_ready  = (state_q == IDLE) ? arb_gnt : '0;
        bus.m_arvalid  = in_addr;
        bus.m_arid     = in_addr ? ID_W'(grant_q) : '0;
        bus.m_araddr   = in_addr ? addr_q : '0;
        bus.m_arlen    = in_addr ? len_q : '0;
        bus.m_arsize   = in_addr ? size_q : '0;
        bus.m_arburst  = in_addr ? BURST_INCR : '0;
        bus.m_rready   = rready;
        bus.resp_valid = '0;
        if (in_data) bus.resp_valid[grant_q] = bus.m_rvalid;
        bus.resp_data  = in_data ? bus.m_rdata : '0;
        bus.resp_err   = in_data & (bus.m_rresp != RESP_OKAY);
        bus.resp_last  = in_data & bus.m_rlast;
        bus.proto_err  = proto_err_q;
    end

endmodule
